// File: rtl/dp_ram_if.sv
// dp_ram_if: dual-port RAM access bus; master drives the request fields, slave returns read data and strobes.
interface dp_ram_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              a_en, a_we, b_en, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic              a_rvalid, b_rvalid;
    modport master (
        output a_en, a_we, a_addr, a_wdata, b_en, b_we, b_addr, b_wdata,
        input  a_rdata, a_rvalid, b_rdata, b_rvalid
    );
    modport slave (
        input  a_en, a_we, a_addr, a_wdata, b_en, b_we, b_addr, b_wdata,
        output a_rdata, a_rvalid, b_rdata, b_rvalid
    );
endinterface

// File: rtl/dp_ram_param.sv
// dp_ram_param: true dual-port RAM with clear sweep, read-valid strobes and A-wins write collision counting.
// Define DPRAM_BYPASS_EN for write-first forwarding on cross-port read/write to the same address.
module dp_ram_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_req,
    dp_ram_if.slave          bus,
    output logic             busy,
    output logic             collision,
    output logic [CNT_W-1:0] coll_cnt
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d, a_fwd, b_fwd;
    logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic              collision_q, collision_d;
    logic [CNT_W-1:0]  coll_cnt_q, coll_cnt_d;
    logic              acc, a_wr, a_rd, b_wr, b_rd, coll;
    always_comb begin
        acc  = state_q == RUN && !clr_req;
        a_wr = acc && bus.a_en && bus.a_we;
        a_rd = acc && bus.a_en && !bus.a_we;
        b_wr = acc && bus.b_en && bus.b_we;
        b_rd = acc && bus.b_en && !bus.b_we;
        coll = a_wr && b_wr && bus.a_addr == bus.b_addr;
`ifdef DPRAM_BYPASS_EN
        a_fwd = (b_wr && bus.b_addr == bus.a_addr) ? bus.b_wdata : mem[bus.a_addr];
        b_fwd = (a_wr && bus.a_addr == bus.b_addr) ? bus.a_wdata : mem[bus.b_addr];
`else
        a_fwd = mem[bus.a_addr];
        b_fwd = mem[bus.b_addr];
`endif
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) state_d = RUN;
        end else if (clr_req) begin
            state_d = CLEAR;
        end
        a_rdata_d   = a_rd ? a_fwd : a_rdata_q;
        b_rdata_d   = b_rd ? b_fwd : b_rdata_q;
        a_rvalid_d  = a_rd;
        b_rvalid_d  = b_rd;
        collision_d = coll;
        coll_cnt_d  = (state_q == RUN && clr_req) ? '0 :
                      (coll && !(&coll_cnt_q)) ? coll_cnt_q + 1'b1 : coll_cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            collision_q <= 1'b0;
            coll_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            collision_q <= collision_d;
            coll_cnt_q  <= coll_cnt_d;
        end
    end
    // Port A is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else begin
            if (b_wr) mem[bus.b_addr] <= bus.b_wdata;
            if (a_wr) mem[bus.a_addr] <= bus.a_wdata;
        end
    end
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign busy         = state_q == CLEAR;
    assign collision    = collision_q;
    assign coll_cnt     = coll_cnt_q;
endmodule

// File: tb/tb_dp_ram_param.sv
// tb_dp_ram_param: directed checks of dp_ram_param; a second instance with CNT_W=2 shadows the stimulus for saturation.
module tb_dp_ram_param;
    logic       clk = 1'b0, rst_n = 1'b0, clr_req = 1'b0;
    logic       busy0, coll0, busy1, coll1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    int         n_chk = 0, n_fail = 0, n;

    dp_ram_if #(.DATA_W(16), .ADDR_W(5)) ifa ();
    dp_ram_if #(.DATA_W(16), .ADDR_W(5)) ifb ();

    assign ifb.a_en = ifa.a_en;  assign ifb.a_we = ifa.a_we;
    assign ifb.a_addr = ifa.a_addr;  assign ifb.a_wdata = ifa.a_wdata;
    assign ifb.b_en = ifa.b_en;  assign ifb.b_we = ifa.b_we;
    assign ifb.b_addr = ifa.b_addr;  assign ifb.b_wdata = ifa.b_wdata;

    dp_ram_param #(.DATA_W(16), .ADDR_W(5), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .bus(ifa.slave),
        .busy(busy0), .collision(coll0), .coll_cnt(cnt0));
    dp_ram_param #(.DATA_W(16), .ADDR_W(5), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .bus(ifb.slave),
        .busy(busy1), .collision(coll1), .coll_cnt(cnt1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic port_a(input logic en, input logic we, input logic [4:0] addr, input logic [15:0] d);
        ifa.a_en = en; ifa.a_we = we; ifa.a_addr = addr; ifa.a_wdata = d;
    endtask

    task automatic port_b(input logic en, input logic we, input logic [4:0] addr, input logic [15:0] d);
        ifa.b_en = en; ifa.b_we = we; ifa.b_addr = addr; ifa.b_wdata = d;
    endtask

    task automatic wait_sweep(input string tag);
        n = 0;
        while (busy0 && n < 100) begin
            cyc();
            n++;
        end
        chk(tag, n, 32);
    endtask

    initial begin
        port_a(0, 0, 0, 0);
        port_b(0, 0, 0, 0);
        #1;
        chk("rst_a_rdata", ifa.a_rdata, 0);
        chk("rst_b_rdata", ifa.b_rdata, 0);
        chk("rst_a_rvalid", ifa.a_rvalid, 0);
        chk("rst_b_rvalid", ifa.b_rvalid, 0);
        chk("rst_collision", coll0, 0);
        chk("rst_coll_cnt", cnt0, 0);
        chk("rst_busy", busy0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sweep("init_sweep_len");
        for (int i = 0; i < 32; i++) begin
            port_a(1, 0, 5'(i), 0);
            port_b(1, 0, 5'(31 - i), 0);
            cyc();
            chk("init_a_rdata", ifa.a_rdata, 0);
            chk("init_a_rvalid", ifa.a_rvalid, 1);
            chk("init_b_rdata", ifa.b_rdata, 0);
            chk("init_b_rvalid", ifa.b_rvalid, 1);
        end
        port_a(1, 1, 3, 16'h1234);
        port_b(0, 0, 0, 0);
        cyc();
        chk("wr_no_a_rvalid", ifa.a_rvalid, 0);
        chk("wr_no_b_rvalid", ifa.b_rvalid, 0);
        port_a(0, 0, 0, 0);
        port_b(1, 0, 3, 0);
        cyc();
        chk("rd3_b_rdata", ifa.b_rdata, 16'h1234);
        chk("rd3_b_rvalid", ifa.b_rvalid, 1);
        chk("rd3_a_rvalid", ifa.a_rvalid, 0);
        port_b(0, 0, 0, 0);
        cyc();
        chk("idle_b_rvalid", ifa.b_rvalid, 0);
        chk("idle_b_hold", ifa.b_rdata, 16'h1234);
        port_a(1, 1, 7, 16'hAAAA);
        port_b(1, 1, 7, 16'h5555);
        cyc();
        chk("coll_strobe", coll0, 1);
        chk("coll_cnt_1", cnt0, 1);
        chk("coll_cnt_1_w2", cnt1, 1);
        port_a(0, 0, 0, 0);
        port_b(0, 0, 0, 0);
        cyc();
        chk("coll_one_cycle", coll0, 0);
        port_b(1, 0, 7, 0);
        cyc();
        chk("coll_a_wins", ifa.b_rdata, 16'hAAAA);
        for (int i = 0; i < 4; i++) begin
            port_a(1, 1, 5'(10 + i), 16'(i));
            port_b(1, 1, 5'(10 + i), 16'hFFFF);
            cyc();
            chk("coll_burst", coll0, 1);
        end
        chk("coll_cnt_5", cnt0, 5);
        chk("coll_cnt_sat", cnt1, 3);
        port_a(1, 1, 9, 16'h0001);
        port_b(0, 0, 0, 0);
        cyc();
        chk("no_coll_single_wr", coll0, 0);
        port_a(1, 1, 9, 16'hBEEF);
        port_b(1, 0, 9, 0);
        cyc();
`ifdef DPRAM_BYPASS_EN
        chk("rw_same_addr", ifa.b_rdata, 16'hBEEF);
`else
        chk("rw_same_addr", ifa.b_rdata, 16'h0001);
`endif
        port_a(1, 0, 9, 0);
        port_b(0, 0, 0, 0);
        cyc();
        chk("rw_written", ifa.a_rdata, 16'hBEEF);
        port_a(1, 1, 0, 16'h5A5A);
        cyc();
        clr_req = 1'b1;
        port_a(1, 1, 0, 16'hFFFF);
        cyc();
        clr_req = 1'b0;
        port_a(0, 0, 0, 0);
        chk("clr_busy", busy0, 1);
        chk("clr_coll_cnt", cnt0, 0);
        chk("clr_coll_cnt_w2", cnt1, 0);
        chk("clr_no_wr_rvalid", ifa.a_rvalid, 0);
        wait_sweep("clr_sweep_len");
        port_a(1, 0, 0, 0);
        port_b(1, 0, 3, 0);
        cyc();
        chk("clr_addr0", ifa.a_rdata, 0);
        chk("clr_addr3", ifa.b_rdata, 0);
        port_a(1, 1, 5, 16'h1111);
        port_b(0, 0, 0, 0);
        cyc();
        port_a(1, 0, 5, 0);
        cyc();
        chk("pre_rst_rdata", ifa.a_rdata, 16'h1111);
        port_a(0, 0, 0, 0);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            port_a(1, 0, 5, 0);
            cyc();
        end
        chk("sweep_drops_rvalid", ifa.a_rvalid, 0);
        chk("sweep_holds_rdata", ifa.a_rdata, 16'h1111);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rdata", ifa.a_rdata, 0);
        chk("async_rst_busy", busy0, 1);
        chk("async_rst_coll", coll0, 0);
        port_a(0, 0, 0, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        wait_sweep("rst_sweep_len");
        port_a(1, 0, 5, 0);
        cyc();
        chk("post_rst_read", ifa.a_rdata, 0);
        chk("post_rst_rvalid", ifa.a_rvalid, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
